// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared encodings for the traffic light controller
package tlc_pkg;

    // Direction request encodings, identical to the master FSM's
    localparam logic [1:0] M_NS  = 2'b00;
    localparam logic [1:0] M_EW  = 2'b01;
    localparam logic [1:0] M_LT  = 2'b10;
    localparam logic [1:0] M_ILL = 2'b11;

    // Lamp group encodings {R,Y,G}
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    // Sequencer states; S_FLASH is only reachable with TLC_FLASH_EN
    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_ALLRED = 2'b10,
        S_FLASH  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - loadable phase down-counter with zero flag
module tlc_phase_timer #(
    parameter int                 TWIDTH  = 4,
    parameter logic [TWIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [TWIDTH-1:0] load_val_i,
    output logic [TWIDTH-1:0] cnt_o,
    output logic              zero_o
);

    logic [TWIDTH-1:0] cnt_q;
    logic [TWIDTH-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, reset to the first phase's preload
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tlc_light_sequencer.sv
// rtl/tlc_light_sequencer.sv - lamp sequencer green/yellow/all-red, optional TLC_FLASH_EN flashing mode
module tlc_light_sequencer
    import tlc_pkg::*;
#(
    parameter int                TWIDTH  = 4,
    parameter logic [TWIDTH-1:0] G_MIN   = 4'd6,
    parameter logic [TWIDTH-1:0] Y_TIME  = 4'd3,
    parameter logic [TWIDTH-1:0] AR_TIME = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dir,
`ifdef TLC_FLASH_EN
    input  logic       flash,
`endif
    output logic       ok,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [2:0] light_lt
);

    localparam logic [TWIDTH-1:0] G_LOAD  = G_MIN - 1'b1;
    localparam logic [TWIDTH-1:0] Y_LOAD  = Y_TIME - 1'b1;
    localparam logic [TWIDTH-1:0] AR_LOAD = AR_TIME - 1'b1;

    seq_state_e        state_q;
    logic [1:0]        served_q;
    logic [1:0]        pending_q;
    logic              blink_q;

    logic [TWIDTH-1:0] cnt;
    logic              zero;
    logic              ld;
    logic [TWIDTH-1:0] ld_val;
    logic              flash_on;

`ifdef TLC_FLASH_EN
    assign flash_on = flash;
`else
    assign flash_on = 1'b0;
`endif

    // Transition events, shared by the timer control and the FSM
    logic go_yel, go_ar, go_grn, fl_enter, fl_exit, fl_tick;
    assign fl_enter = flash_on && (state_q != S_FLASH);
    assign fl_exit  = !flash_on && (state_q == S_FLASH);
    assign fl_tick  = flash_on && (state_q == S_FLASH) && zero;
    assign go_yel   = (state_q == S_GREEN) && zero && (dir != served_q) && (dir != M_ILL);
    assign go_ar    = (state_q == S_YELLOW) && zero;
    assign go_grn   = (state_q == S_ALLRED) && zero;

    // Select the preload for whichever phase is being entered
    always_comb begin
        ld     = 1'b0;
        ld_val = G_LOAD;
        if (fl_enter || fl_tick) begin
            ld     = 1'b1;
            ld_val = G_LOAD;
        end else if (fl_exit || go_ar) begin
            ld     = 1'b1;
            ld_val = AR_LOAD;
        end else if (go_yel) begin
            ld     = 1'b1;
            ld_val = Y_LOAD;
        end else if (go_grn) begin
            ld     = 1'b1;
            ld_val = G_LOAD;
        end
    end

    tlc_phase_timer #(
        .TWIDTH  (TWIDTH),
        .RST_VAL (G_LOAD)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (ld),
        .load_val_i (ld_val),
        .cnt_o      (cnt),
        .zero_o     (zero)
    );

    // Phase FSM: served/pending bookkeeping and flash blink phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_GREEN;
            served_q  <= M_NS;
            pending_q <= M_NS;
            blink_q   <= 1'b1;
        end else if (fl_enter) begin
            state_q   <= S_FLASH;
            blink_q   <= 1'b1;
        end else if (fl_exit) begin
            state_q   <= S_ALLRED;
            pending_q <= M_NS;
        end else if (fl_tick) begin
            blink_q   <= !blink_q;
        end else if (go_yel) begin
            state_q   <= S_YELLOW;
            pending_q <= dir;
        end else if (go_ar) begin
            state_q   <= S_ALLRED;
        end else if (go_grn) begin
            state_q   <= S_GREEN;
            served_q  <= pending_q;
        end
    end

    // Moore lamp and ok decode from state registers and counter
    always_comb begin
        ok       = 1'b0;
        light_ns = L_RED;
        light_ew = L_RED;
        light_lt = L_RED;
        case (state_q)
            S_GREEN: begin
                ok       = zero;
                light_ns = (served_q == M_NS) ? L_GRN : L_RED;
                light_ew = (served_q == M_EW) ? L_GRN : L_RED;
                light_lt = (served_q == M_LT) ? L_GRN : L_RED;
            end
            S_YELLOW: begin
                light_ns = (served_q == M_NS) ? L_YEL : L_RED;
                light_ew = (served_q == M_EW) ? L_YEL : L_RED;
                light_lt = (served_q == M_LT) ? L_YEL : L_RED;
            end
            S_FLASH: begin
                light_ns = blink_q ? L_YEL : L_OFF;
                light_ew = blink_q ? L_RED : L_OFF;
                light_lt = blink_q ? L_RED : L_OFF;
            end
            default: begin
                ok = 1'b0;
            end
        endcase
    end

endmodule
